// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
// Shares one combinational execute ALU between the instruction pipeline
// (requester 0) and the address-generation unit (requester 1). Round-robin
// grant in IDLE, operands held on the ALU for 1 or MUL_LAT cycles in EXEC,
// captured result returned over a per-requester response handshake in RESP.
//
// Handshake semantics: a request transfers in the cycle where reqN_valid and
// reqN_ready are both high; a response transfers in the cycle where
// rspN_valid and rspN_ready are both high. Valid never depends on ready.
// reqN_ready is combinational from state and the valids (no bubble in IDLE),
// and only the winner ever sees ready.
module alu_issue_arbiter #(
    parameter int         MUL_LAT = 3,
    parameter logic [3:0] MUL_OP  = 4'b1010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_src,
    input  logic [31:0] alu_result,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);

    state_t      state_q, state_d;
    logic        prio_q;
    logic        owner_q;
    logic [3:0]  cnt_q;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] result_q;
    logic        zero_q;

    logic        grant0, grant1;
    logic        capture;
    logic        rsp_done;
    logic [3:0]  win_op;

    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign alu_src    = 2'b00;
    assign dbg_state  = state_q;
    assign win_op     = grant1 ? req1_op : req0_op;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, grant, ALU drive and response valids.
    always_comb begin
        state_d    = state_q;
        grant0     = 1'b0;
        grant1     = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        alu_op     = 4'd0;
        alu_a      = 32'd0;
        alu_b      = 32'd0;
        case (state_q)
            IDLE: begin
                // On contention the pointer picks; otherwise the lone valid wins.
                if (req0_valid && req1_valid) begin
                    grant0 = !prio_q;
                    grant1 = prio_q;
                end else begin
                    grant0 = req0_valid;
                    grant1 = req1_valid;
                end
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) state_d = EXEC;
            end
            EXEC: begin
                alu_op = op_q;
                alu_a  = a_q;
                alu_b  = b_q;
                if (cnt_q == 4'd1) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp0_valid = !owner_q;
                rsp1_valid = owner_q;
                rsp_done   = owner_q ? rsp1_ready : rsp0_ready;
                if (rsp_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, cycle counter, result capture and priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 4'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            owner_q  <= 1'b0;
            cnt_q    <= 4'd0;
            result_q <= 32'd0;
            zero_q   <= 1'b1;
            prio_q   <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                op_q    <= win_op;
                a_q     <= grant1 ? req1_a : req0_a;
                b_q     <= grant1 ? req1_b : req0_b;
                owner_q <= grant1;
                cnt_q   <= (win_op == MUL_OP) ? MUL_CNT : 4'd1;
            end else if (state_q == EXEC) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                result_q <= alu_result;
                zero_q   <= (alu_result == 32'd0);
            end
            // Pointer moves only once the response has been taken.
            if (rsp_done) prio_q <= !owner_q;
        end
    end

endmodule
